v_decode_queue: RTL and testbench
=================================

Name: v_decode_queue

Overview:
- Parametrised, pipelined successor to the combinational vector decoder.
- Buffers incoming 32-bit RVV instructions in an instruction FIFO and decodes the head into a registered output stage with valid/ready handshakes on both sides.
- Owns the architectural vl/vtype state: executes vsetvli/vsetivli/vsetvl itself and tags every dispatched instruction with the vl/vtype in effect.
- Sits between the scalar core's offload interface and the vector execution units (VALU, VMUL, VLSU, VSLDU, VRED).

Parameters:
- VLEN, 512, vector register length in bits (power of 2, ≥ 64).
- ELEN, 32, maximum element width in bits; SEW > ELEN sets vill.
- FIFO_DEPTH, 4, instruction FIFO entries (power of 2, ≥ 2).
- OFF_SIGNAL, 0, op code driven on unit op ports that are not selected.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instruction offered.
- in_ready  out  1  FIFO not full.
- in_instr  in  32  instruction word.
- in_rs1_data  in  32  scalar rs1 value (AVL, base address).
- in_rs2_data  in  32  scalar rs2 value (stride, vsetvl vtype).
- out_valid  out  1  decoded instruction present.
- out_ready  in  1  downstream accepts.
- v_alu_op, v_mul_op, v_lsu_op, v_sldu_op, v_red_op  out  6 each  funct6 on the selected unit, OFF_SIGNAL elsewhere.
- vd, vrs1, vrs2, imm  out  5 each  decoded fields.
- rs1_data, rs2_data  out  32 each  forwarded scalars.
- vl  out  $clog2(VLEN)+1  vl in effect.
- vsew  out  3  SEW code in effect.
- vlmul  out  3  LMUL code in effect.
- is_vconfig  out  1  config instruction.
- illegal  out  1  unsupported encoding.
- rd_we  out  1  scalar writeback of new vl.
- rd_data  out  32  new vl value.

Behaviour:
- Reset (nrst low, asynchronous):
  - FIFO emptied, out_valid=0, all op ports=OFF_SIGNAL, fields=0.
  - vl=0, vsew=0, vlmul=0, vill=1, rd_we=0, illegal=0.
  - Any in-flight instruction is discarded.
- FIFO:
  - Push when in_valid && in_ready; pop when the decode register loads.
  - in_ready=0 only when full. Push while full is ignored.
  - Simultaneous push and pop while full is accepted: the pop frees a slot the same cycle.
  - Pointer wrap is modulo FIFO_DEPTH.
  - An empty FIFO with push bypasses nothing: minimum latency from accept to out_valid is 2 cycles.
- Decode register:
  - Loads the FIFO head when FIFO non-empty && (!out_valid || out_ready).
  - Holds all outputs stable while out_valid && !out_ready.
- Unit select:
  - LOAD-FP/STORE-FP opcodes go to v_lsu_op.
  - OP-V with funct3 OPMVV or OPMVX, and funct6 in the reduction group (000000–000111), goes to v_red_op.
  - OP-V with funct3 OPMVV or OPMVX, and funct6 in the multiply group (100100–101111), goes to v_mul_op.
  - OP-V funct6 in the slide/gather group (001100–001111) goes to v_sldu_op.
  - Other OPIVV/OPIVI/OPIVX instructions go to v_alu_op.
  - Exactly one op port is non-OFF per instruction.
  - OPFVV/OPFVF and unknown opcodes: illegal=1, all op ports OFF.
- Field rules:
  - VI form: vrs1=0, imm=instr[19:15].
  - VX and load/store forms: vrs1 carries the rs1 index.
  - Unit-stride memory ops: vrs2=0.
  - Strided memory ops: rs2_data is the stride.
- Config instructions (OP-V, funct3=111):
  - Encodings: instr[31]=0 is vsetvli; instr[31:30]=11 is vsetivli (AVL = uimm instr[19:15]); instr[31:25]=1000000 is vsetvl (vtype = rs2_data[7:0]).
  - VLMAX = (VLEN/SEW) × LMUL. LMUL is integer only (vlmul codes 000–011).
  - vill=1 if vlmul is fractional or reserved, SEW > ELEN, or vtype reserved bits are non-zero. When vill=1, vl=0.
  - AVL source: rs1_data, or uimm for vsetivli.
  - Register-AVL forms with rs1 index=0 and rd≠0: vl=VLMAX.
  - Register-AVL forms with rs1=0 and rd=0: vl unchanged. If VLMAX changes, vl is clamped to the new VLMAX.
  - Otherwise vl=min(AVL, VLMAX).
  - The new vl/vtype updates the architectural registers in the cycle the config instruction loads the decode register.
  - Every later instruction is tagged with the new values; the config instruction itself is tagged with the new values.
  - rd_we=1 and rd_data=new vl, valid with out_valid. All unit op ports are OFF.
- Back-to-back configs are applied in program order. No bubbles are required.

Decomposition:
- v_pkg holds:
  - opcode constants: OPC_LTYPE, OPC_STYPE, OPC_RTYPE.
  - funct3 constants: OPI_VV/VI/VX, OPM_VV/VX, OP_SET.
  - MOP codes and funct6 group boundaries.
  - vtype_t struct (vill, vma, vta, vsew, vlmul).
  - decoded_instr_t struct used for the output register.
- Natural sub-module: v_instr_fifo (parametrised synchronous FIFO, FIFO_DEPTH × 96 bits: instr, rs1_data, rs2_data).

Test Plan:
- Reset state: hold nrst low, then release → in_ready=1, out_valid=0, vl=0, vill=1.
- vsetvli x5,x10,e32,m2 with rs1_data=100 → vl=32, vsew=010, vlmul=001, rd_we=1, rd_data=32. Repeat with rs1_data=20 → vl=20.
- Unit routing: vadd.vv v3,v1,v2 (0x022081D7) → v_alu_op=000000, all other op ports OFF, vl tag=20. Then vmul.vv → only v_mul_op=100101.
- Backpressure: out_ready=0, push FIFO_DEPTH+2 instructions → in_ready falls after 4 accepted pushes plus 1 in the decode register; outputs stay stable. Release → instructions drain in order, no loss or duplication.
- Illegal/vill cases: OPFVV instruction → illegal=1, op ports OFF. vsetvli with vlmul=111 → vill=1, vl=0.
- Asynchronous reset mid-stream with 3 entries queued → next edge shows out_valid=0, FIFO empty, vl=0, without waiting for clk.

Source files
------------

// File: rtl/v_pkg.sv
// Shared encodings and record types for the queued RVV decoder.
// Opcode/funct3 constants, funct6 unit groups, vtype and the decode-register record.
package v_pkg;

    localparam logic [6:0] OPC_LTYPE = 7'b0000111;
    localparam logic [6:0] OPC_STYPE = 7'b0100111;
    localparam logic [6:0] OPC_RTYPE = 7'b1010111;

    localparam logic [2:0] OPI_VV = 3'b000, OPF_VV = 3'b001, OPM_VV = 3'b010, OPI_VI = 3'b011,
                           OPI_VX = 3'b100, OPF_VF = 3'b101, OPM_VX = 3'b110, OP_SET = 3'b111;

    localparam logic [1:0] MOP_UNIT = 2'b00, MOP_IDX_U = 2'b01, MOP_STRIDE = 2'b10, MOP_IDX_O = 2'b11;

    localparam logic [5:0] F6_RED_LO = 6'b000000, F6_RED_HI = 6'b000111;
    localparam logic [5:0] F6_SLD_LO = 6'b001100, F6_SLD_HI = 6'b001111;
    localparam logic [5:0] F6_MUL_LO = 6'b100100, F6_MUL_HI = 6'b101111;

    typedef struct packed {
        logic       vill;
        logic       vma;
        logic       vta;
        logic [2:0] vsew;
        logic [2:0] vlmul;
    } vtype_t;

    typedef struct packed {
        logic [5:0]  alu_op;
        logic [5:0]  mul_op;
        logic [5:0]  lsu_op;
        logic [5:0]  sldu_op;
        logic [5:0]  red_op;
        logic [4:0]  vd;
        logic [4:0]  vrs1;
        logic [4:0]  vrs2;
        logic [4:0]  imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] vl;
        vtype_t      vtype;
        logic        is_vconfig;
        logic        illegal;
        logic        rd_we;
        logic [31:0] rd_data;
    } decoded_instr_t;

    function automatic logic f6_in(input logic [5:0] f6, input logic [5:0] lo, input logic [5:0] hi);
        return (f6 >= lo) && (f6 <= hi);
    endfunction

endpackage

// File: rtl/v_instr_fifo.sv
// Synchronous instruction FIFO; a pop in the same cycle frees a slot for a push while full.
module v_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/v_decode_queue.sv
// Queued RVV decoder: FIFO-buffered instructions decoded into a registered, handshaked output
// stage; owns vl/vtype and executes vsetvli/vsetivli/vsetvl itself.
module v_decode_queue
    import v_pkg::*;
#(
    parameter int         VLEN       = 512,
    parameter int         ELEN       = 32,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [5:0] OFF_SIGNAL = 6'd0
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [31:0]            in_rs1_data,
    input  logic [31:0]            in_rs2_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [5:0]             v_alu_op,
    output logic [5:0]             v_mul_op,
    output logic [5:0]             v_lsu_op,
    output logic [5:0]             v_sldu_op,
    output logic [5:0]             v_red_op,
    output logic [4:0]             vd,
    output logic [4:0]             vrs1,
    output logic [4:0]             vrs2,
    output logic [4:0]             imm,
    output logic [31:0]            rs1_data,
    output logic [31:0]            rs2_data,
    output logic [$clog2(VLEN):0]  vl,
    output logic [2:0]             vsew,
    output logic [2:0]             vlmul,
    output logic                   is_vconfig,
    output logic                   illegal,
    output logic                   rd_we,
    output logic [31:0]            rd_data
);
    localparam int VL_W = $clog2(VLEN) + 1;
    localparam decoded_instr_t DEC_RST = '{alu_op: OFF_SIGNAL, mul_op: OFF_SIGNAL, lsu_op: OFF_SIGNAL,
                                           sldu_op: OFF_SIGNAL, red_op: OFF_SIGNAL, default: '0};
    localparam vtype_t VTYPE_RST = '{vill: 1'b1, default: '0};

    function automatic logic [31:0] vlmax_of(input logic [2:0] sew_code, input logic [2:0] lmul_code);
        return (32'(VLEN) >> (32'(sew_code) + 32'd3)) << lmul_code;
    endfunction

    function automatic logic [31:0] sat_vl(input logic [31:0] avl, input logic [31:0] vlmax);
        return (avl < vlmax) ? avl : vlmax;
    endfunction

    logic           fifo_empty, fifo_full, load_p1, vld_p1;
    logic [95:0]    head_p0;
    logic [31:0]    instr_p0, rs1_p0, rs2_p0;
    logic [6:0]     opc_p0;
    logic [2:0]     f3_p0;
    logic [5:0]     f6_p0;
    decoded_instr_t dec_p0, dec_p1;
    vtype_t         vtype_q, vtype_nxt;
    logic [31:0]    vl_q, vl_nxt;
    logic           cfg_ok, reg_avl, cfg_rsvd, new_vill;
    logic [7:0]     cfg_bits;
    logic [31:0]    avl, vlmax;

    assign in_ready = !fifo_full;
    assign load_p1  = !fifo_empty && (!vld_p1 || out_ready);

    v_instr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(96)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (in_valid),
        .wdata ({in_instr, in_rs1_data, in_rs2_data}),
        .pop   (load_p1),
        .rdata (head_p0),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // p0: decode the FIFO head and compute the vl/vtype it would establish
    assign {instr_p0, rs1_p0, rs2_p0} = head_p0;
    assign opc_p0 = instr_p0[6:0];
    assign f3_p0  = instr_p0[14:12];
    assign f6_p0  = instr_p0[31:26];

    always_comb begin
        dec_p0          = DEC_RST;
        dec_p0.vd       = instr_p0[11:7];
        dec_p0.vrs1     = instr_p0[19:15];
        dec_p0.vrs2     = instr_p0[24:20];
        dec_p0.rs1_data = rs1_p0;
        dec_p0.rs2_data = rs2_p0;
        vtype_nxt = vtype_q;
        vl_nxt    = vl_q;
        cfg_ok    = 1'b0;
        reg_avl   = 1'b0;
        cfg_rsvd  = 1'b0;
        new_vill  = 1'b0;
        cfg_bits  = '0;
        avl       = '0;
        vlmax     = '0;

        if (opc_p0 == OPC_LTYPE || opc_p0 == OPC_STYPE) begin
            dec_p0.lsu_op = f6_p0;
            if (instr_p0[27:26] == MOP_UNIT) dec_p0.vrs2 = '0;
        end else if (opc_p0 == OPC_RTYPE) begin
            case (f3_p0)
                OP_SET: begin
                    dec_p0.vrs2 = '0;
                    if (!instr_p0[31]) begin
                        cfg_ok   = 1'b1;
                        reg_avl  = 1'b1;
                        cfg_bits = instr_p0[27:20];
                        cfg_rsvd = |instr_p0[30:28];
                        avl      = rs1_p0;
                    end else if (instr_p0[31:30] == 2'b11) begin
                        cfg_ok      = 1'b1;
                        cfg_bits    = instr_p0[27:20];
                        cfg_rsvd    = |instr_p0[29:28];
                        avl         = 32'(instr_p0[19:15]);
                        dec_p0.vrs1 = '0;
                        dec_p0.imm  = instr_p0[19:15];
                    end else if (instr_p0[31:25] == 7'b1000000) begin
                        cfg_ok   = 1'b1;
                        reg_avl  = 1'b1;
                        cfg_bits = rs2_p0[7:0];
                        cfg_rsvd = |rs2_p0[31:8];
                        avl      = rs1_p0;
                    end else begin
                        dec_p0.illegal = 1'b1;
                    end
                end
                OPF_VV, OPF_VF: dec_p0.illegal = 1'b1;
                OPM_VV, OPM_VX: begin
                    if (f6_in(f6_p0, F6_RED_LO, F6_RED_HI))      dec_p0.red_op  = f6_p0;
                    else if (f6_in(f6_p0, F6_MUL_LO, F6_MUL_HI)) dec_p0.mul_op  = f6_p0;
                    else if (f6_in(f6_p0, F6_SLD_LO, F6_SLD_HI)) dec_p0.sldu_op = f6_p0;
                    else                                         dec_p0.illegal = 1'b1;
                end
                default: begin
                    if (f6_in(f6_p0, F6_SLD_LO, F6_SLD_HI)) dec_p0.sldu_op = f6_p0;
                    else                                    dec_p0.alu_op  = f6_p0;
                    if (f3_p0 == OPI_VI) begin
                        dec_p0.vrs1 = '0;
                        dec_p0.imm  = instr_p0[19:15];
                    end
                end
            endcase
        end else begin
            dec_p0.illegal = 1'b1;
        end

        // Fractional/reserved LMUL, SEW > ELEN or reserved bits set all land in vill with vl=0.
        if (cfg_ok) begin
            new_vill = cfg_rsvd || cfg_bits[2] || cfg_bits[5] ||
                       ((32'd8 << cfg_bits[5:3]) > 32'(ELEN));
            vlmax    = vlmax_of(cfg_bits[5:3], cfg_bits[2:0]);
            if (new_vill) begin
                vtype_nxt = VTYPE_RST;
                vl_nxt    = '0;
            end else begin
                vtype_nxt = '{vill: 1'b0, vma: cfg_bits[7], vta: cfg_bits[6],
                              vsew: cfg_bits[5:3], vlmul: cfg_bits[2:0]};
                if (reg_avl && instr_p0[19:15] == 5'd0 && instr_p0[11:7] != 5'd0) vl_nxt = vlmax;
                else if (reg_avl && instr_p0[19:15] == 5'd0)                       vl_nxt = sat_vl(vl_q, vlmax);
                else                                                               vl_nxt = sat_vl(avl, vlmax);
            end
            dec_p0.is_vconfig = 1'b1;
            dec_p0.rd_we      = 1'b1;
            dec_p0.rd_data    = vl_nxt;
        end
        dec_p0.vl    = vl_nxt;
        dec_p0.vtype = vtype_nxt;
    end

    // p1: decode register and architectural vl/vtype, both committed on load
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p1  <= 1'b0;
            dec_p1  <= DEC_RST;
            vtype_q <= VTYPE_RST;
            vl_q    <= '0;
        end else if (load_p1) begin
            vld_p1  <= 1'b1;
            dec_p1  <= dec_p0;
            vtype_q <= vtype_nxt;
            vl_q    <= vl_nxt;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid  = vld_p1;
    assign v_alu_op   = dec_p1.alu_op;
    assign v_mul_op   = dec_p1.mul_op;
    assign v_lsu_op   = dec_p1.lsu_op;
    assign v_sldu_op  = dec_p1.sldu_op;
    assign v_red_op   = dec_p1.red_op;
    assign vd         = dec_p1.vd;
    assign vrs1       = dec_p1.vrs1;
    assign vrs2       = dec_p1.vrs2;
    assign imm        = dec_p1.imm;
    assign rs1_data   = dec_p1.rs1_data;
    assign rs2_data   = dec_p1.rs2_data;
    assign vl         = dec_p1.vl[VL_W-1:0];
    assign vsew       = dec_p1.vtype.vsew;
    assign vlmul      = dec_p1.vtype.vlmul;
    assign is_vconfig = dec_p1.is_vconfig;
    assign illegal    = dec_p1.illegal;
    assign rd_we      = dec_p1.rd_we;
    assign rd_data    = dec_p1.rd_data;

    logic unused_tag_bits;
    assign unused_tag_bits = ^{dec_p1.vl[31:VL_W], dec_p1.vtype.vill, dec_p1.vtype.vma, dec_p1.vtype.vta};

endmodule

// File: tb/tb_v_decode_queue.sv
// Directed bench for v_decode_queue with an expected-output scoreboard.
module tb_v_decode_queue;
    localparam int         VLEN = 512;
    localparam int         ELEN = 32;
    localparam int         FD   = 4;
    localparam logic [5:0] OFF  = 6'd0;

    logic        clk = 1'b0, nrst = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_rs1_data = '0, in_rs2_data = '0;
    logic [5:0]  v_alu_op, v_mul_op, v_lsu_op, v_sldu_op, v_red_op;
    logic [4:0]  vd, vrs1, vrs2, imm;
    logic [31:0] rs1_data, rs2_data, rd_data;
    logic [9:0]  vl;
    logic [2:0]  vsew, vlmul;
    logic        is_vconfig, illegal, rd_we;

    always #5 clk = ~clk;

    v_decode_queue #(.VLEN(VLEN), .ELEN(ELEN), .FIFO_DEPTH(FD), .OFF_SIGNAL(OFF)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .out_valid(out_valid),
        .out_ready(out_ready), .v_alu_op(v_alu_op), .v_mul_op(v_mul_op), .v_lsu_op(v_lsu_op),
        .v_sldu_op(v_sldu_op), .v_red_op(v_red_op), .vd(vd), .vrs1(vrs1), .vrs2(vrs2), .imm(imm),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .vl(vl), .vsew(vsew), .vlmul(vlmul),
        .is_vconfig(is_vconfig), .illegal(illegal), .rd_we(rd_we), .rd_data(rd_data)
    );

    typedef struct packed {
        logic [29:0] ops;     // alu, mul, lsu, sldu, red
        logic [19:0] fields;  // vd, vrs1, vrs2, imm
        logic [15:0] tag;     // vl, vsew, vlmul
        logic [34:0] cfg;     // is_vconfig, illegal, rd_we, rd_data
        logic [63:0] data;    // rs1_data, rs2_data
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t observe();
        exp_t o;
        o.ops    = {v_alu_op, v_mul_op, v_lsu_op, v_sldu_op, v_red_op};
        o.fields = {vd, vrs1, vrs2, imm};
        o.tag    = {vl, vsew, vlmul};
        o.cfg    = {is_vconfig, illegal, rd_we, rd_data};
        o.data   = {rs1_data, rs2_data};
        return o;
    endfunction

    // unit: 0 alu, 1 mul, 2 lsu, 3 sldu, 4 red, 5 none
    function automatic exp_t mk(input int unit, input logic [5:0] f6,
                                input logic [4:0] e_vd, input logic [4:0] e_vrs1,
                                input logic [4:0] e_vrs2, input logic [4:0] e_imm,
                                input logic [9:0] e_vl, input logic [2:0] e_sew, input logic [2:0] e_lmul,
                                input logic e_cfg, input logic e_ill, input logic [31:0] e_rdd);
        exp_t e;
        logic [5:0] p [5];
        for (int i = 0; i < 5; i++) p[i] = (i == unit) ? f6 : OFF;
        e.ops    = {p[0], p[1], p[2], p[3], p[4]};
        e.fields = {e_vd, e_vrs1, e_vrs2, e_imm};
        e.tag    = {e_vl, e_sew, e_lmul};
        e.cfg    = {e_cfg, e_ill, e_cfg, e_rdd};
        e.data   = '0;
        return e;
    endfunction

    task automatic compare(input string where, input exp_t e);
        exp_t o;
        o = observe();
        chk({where, "_ops"},    64'(o.ops),    64'(e.ops));
        chk({where, "_fields"}, 64'(o.fields), 64'(e.fields));
        chk({where, "_tag"},    64'(o.tag),    64'(e.tag));
        chk({where, "_cfg"},    64'(o.cfg),    64'(e.cfg));
        chk({where, "_data"},   o.data,        e.data);
    endtask

    always @(negedge clk) begin
        if (nrst && out_valid && out_ready) begin
            chk("out_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) compare("out", sb.pop_front());
        end
    end

    function automatic logic [31:0] opv(input logic [5:0] f6, input logic [4:0] vs2, input logic [4:0] vs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f6, 1'b1, vs2, vs1, f3, rd, 7'b1010111};
    endfunction
    function automatic logic [31:0] vsetvli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'b1010111};
    endfunction
    function automatic logic [31:0] vsetivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
    endfunction
    function automatic logic [31:0] vsetvl(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'b1010111};
    endfunction
    function automatic logic [31:0] vmem(input logic [6:0] opc, input logic [2:0] nf, input logic [1:0] mop,
                                         input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {nf, 1'b0, mop, 1'b1, rs2, rs1, 3'b110, rd, opc};
    endfunction

    task automatic push(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("push_ready", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        e.data      = {rs1, rs2};
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1);
    end

    initial begin
        // Reset state, observed both during and after reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ops", 64'({v_alu_op, v_mul_op, v_lsu_op, v_sldu_op, v_red_op}), 64'({5{OFF}}));
        nrst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_vl", 64'(vl), 64'd0);
        chk("rst_vill", 64'(dut.vtype_q.vill), 64'd1);
        chk("rst_flags", 64'({rd_we, illegal}), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // vsetvli x5,x10,e32,m2 with two-cycle accept-to-valid latency
        push(vsetvli(5, 10, 11'h011), 100, 0, mk(5, OFF, 5, 10, 0, 0, 32, 3'd2, 3'd1, 1, 0, 32));
        chk("lat_cycle1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_cycle2", 64'(out_valid), 64'd1);
        drain(20);
        push(vsetvli(5, 10, 11'h011), 20, 0, mk(5, OFF, 5, 10, 0, 0, 20, 3'd2, 3'd1, 1, 0, 20));

        // Unit routing and field rules
        push(32'h022081D7, 1, 2, mk(0, 6'b000000, 3, 1, 2, 0, 20, 3'd2, 3'd1, 0, 0, 0));
        push(opv(6'b100101, 2, 1, 3'b010, 4), 0, 0, mk(1, 6'b100101, 4, 1, 2, 0, 20, 3'd2, 3'd1, 0, 0, 0));
        push(opv(6'b000010, 3, 7, 3'b100, 5), 55, 0, mk(0, 6'b000010, 5, 7, 3, 0, 20, 3'd2, 3'd1, 0, 0, 0));
        push(opv(6'b000011, 4, 5'b11101, 3'b011, 6), 0, 0, mk(0, 6'b000011, 6, 0, 4, 5'h1D, 20, 3'd2, 3'd1, 0, 0, 0));
        push(opv(6'b000111, 8, 9, 3'b010, 10), 0, 0, mk(4, 6'b000111, 10, 9, 8, 0, 20, 3'd2, 3'd1, 0, 0, 0));
        push(opv(6'b001111, 12, 11, 3'b100, 13), 3, 0, mk(3, 6'b001111, 13, 11, 12, 0, 20, 3'd2, 3'd1, 0, 0, 0));
        push(vmem(7'b0000111, 3'b000, 2'b10, 6, 11, 8), 32'h1000, 64, mk(2, 6'b000010, 8, 11, 6, 0, 20, 3'd2, 3'd1, 0, 0, 0));
        push(vmem(7'b0100111, 3'b001, 2'b00, 5'b01011, 12, 9), 32'h2000, 0, mk(2, 6'b001000, 9, 12, 0, 0, 20, 3'd2, 3'd1, 0, 0, 0));
        push(opv(6'b000000, 1, 2, 3'b001, 3), 0, 0, mk(5, OFF, 3, 2, 1, 0, 20, 3'd2, 3'd1, 0, 1, 0));
        drain(40);

        // vill from reserved LMUL, then back-to-back configs applied in order
        push(vsetvli(5, 10, 11'h007), 50, 0, mk(5, OFF, 5, 10, 0, 0, 0, 3'd0, 3'd0, 1, 0, 0));
        drain(20);
        chk("vill_lmul", 64'(dut.vtype_q.vill), 64'd1);
        push(vsetivli(3, 7, 10'h000), 0, 0, mk(5, OFF, 3, 0, 0, 7, 7, 3'd0, 3'd0, 1, 0, 7));
        push(vsetvli(5, 0, 11'h00A), 0, 0, mk(5, OFF, 5, 0, 0, 0, 128, 3'd1, 3'd2, 1, 0, 128));
        push(vsetvli(0, 0, 11'h010), 0, 0, mk(5, OFF, 0, 0, 0, 0, 16, 3'd2, 3'd0, 1, 0, 16));
        push(vsetvl(1, 2, 3), 1000, 32'h13, mk(5, OFF, 1, 2, 0, 0, 128, 3'd2, 3'd3, 1, 0, 128));
        push(vsetvli(4, 6, 11'h018), 9, 0, mk(5, OFF, 4, 6, 0, 0, 0, 3'd0, 3'd0, 1, 0, 0));
        drain(20);
        chk("vill_sew", 64'(dut.vtype_q.vill), 64'd1);
        push(vsetvli(5, 10, 11'h011), 20, 0, mk(5, OFF, 5, 10, 0, 0, 20, 3'd2, 3'd1, 1, 0, 20));
        drain(20);
        chk("vill_clear", 64'(dut.vtype_q.vill), 64'd0);

        // Backpressure: FIFO_DEPTH entries plus one held in the decode register
        out_ready = 1'b0;
        for (int i = 0; i < FD + 1; i++)
            push(opv(6'b000010, 3, 7, 3'b100, 5), 32'(100 + i), 0, mk(0, 6'b000010, 5, 7, 3, 0, 20, 3'd2, 3'd1, 0, 0, 0));
        chk("bp_full", 64'(in_ready), 64'd0);
        in_valid    = 1'b1;
        in_instr    = opv(6'b000010, 3, 7, 3'b100, 5);
        in_rs1_data = 32'd999;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_still_full", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            compare("bp_hold", sb[0]);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain(40);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_extra", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-cycle with entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push(opv(6'b000010, 3, 7, 3'b100, 5), 32'(200 + i), 0, mk(0, 6'b000010, 5, 7, 3, 0, 20, 3'd2, 3'd1, 0, 0, 0));
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_vl", 64'(vl), 64'd0);
        chk("arst_vill", 64'(dut.vtype_q.vill), 64'd1);
        sb.delete();
        @(posedge clk); #1;
        nrst      = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("arst_fifo_empty", 64'(out_valid), 64'd0);
        push(32'h022081D7, 1, 2, mk(0, 6'b000000, 3, 1, 2, 0, 0, 3'd0, 3'd0, 0, 0, 0));
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
